// File: rtl/dmem_port_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_port_arbiter
//   Shares the single-port data RAM between the CPU memory stage and the
//   debug/loader port. Each requester uses a req/ack handshake; the RAM is
//   driven with active-low read/write strobes.
//
// Ports
//   CLK, RST                      clock (rising edge), async active-high reset
//   cpu_req/we/addr/wdata         CPU request, held stable until cpu_ack
//   cpu_ack, cpu_rdata            one-cycle completion pulse, registered read data
//   dbg_*                         same set for the debug/loader port
//   mem_rd_n, mem_wr_n            RAM strobes, active-low, low only in ACCESS
//   mem_addr, mem_wdata           latched address / write data of current access
//   mem_rdata                     RAM read data, valid RD_LAT cycles after access
//   owner                         0 = CPU, 1 = debug (current or last grant)
//   busy                          1 whenever the FSM is not in IDLE
//
// State   | meaning
// --------+---------------------------------------------------------------
// IDLE    | waiting for a request; arbitrates and latches the winner
// ACCESS  | one cycle with the strobe for the latched access asserted
// WAIT    | RD_LAT cycles of read latency; captures mem_rdata on the last
// RESP    | one-cycle ack to the owner, then back to IDLE
// -----------------------------------------------------------------------------
module dmem_port_arbiter #(
  parameter int AW     = 32,
  parameter int DW     = 32,
  parameter int RD_LAT = 1
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_ack,
  output logic [DW-1:0] cpu_rdata,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  output logic          dbg_ack,
  output logic [DW-1:0] dbg_rdata,
  output logic          mem_rd_n,
  output logic          mem_wr_n,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          owner,
  output logic          busy
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_WAIT   = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  // Counter runs RD_LAT-1 .. 0; the capture happens on the zero cycle.
  localparam logic [2:0] LP_WAIT_INIT = 3'(RD_LAT - 1);

  state_t      r_state;
  logic        r_last;
  logic        r_we;
  logic [2:0]  r_cnt;

  logic          w_grant_dbg;
  logic          w_sel_we;
  logic [AW-1:0] w_sel_addr;
  logic [DW-1:0] w_sel_wdata;

  // Tie goes to the port not served last; a lone requester always wins.
  assign w_grant_dbg = (cpu_req && dbg_req) ? ~r_last : dbg_req;
  assign w_sel_we    = w_grant_dbg ? dbg_we    : cpu_we;
  assign w_sel_addr  = w_grant_dbg ? dbg_addr  : cpu_addr;
  assign w_sel_wdata = w_grant_dbg ? dbg_wdata : cpu_wdata;

  assign busy = (r_state != S_IDLE);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state   <= S_IDLE;
      r_last    <= 1'b1;
      r_we      <= 1'b0;
      r_cnt     <= '0;
      owner     <= 1'b0;
      cpu_ack   <= 1'b0;
      dbg_ack   <= 1'b0;
      cpu_rdata <= '0;
      dbg_rdata <= '0;
      mem_rd_n  <= 1'b1;
      mem_wr_n  <= 1'b1;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cpu_req || dbg_req) begin
            owner     <= w_grant_dbg;
            r_we      <= w_sel_we;
            mem_addr  <= w_sel_addr;
            mem_wdata <= w_sel_wdata;
            // Strobes are registered so they are low for exactly the ACCESS cycle.
            mem_wr_n  <= ~w_sel_we;
            mem_rd_n  <= w_sel_we;
            r_state   <= S_ACCESS;
          end
        end

        S_ACCESS: begin
          mem_rd_n <= 1'b1;
          mem_wr_n <= 1'b1;
          if (r_we) begin
            cpu_ack <= ~owner;
            dbg_ack <= owner;
            r_last  <= owner;
            r_state <= S_RESP;
          end else begin
            r_cnt   <= LP_WAIT_INIT;
            r_state <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (r_cnt == 3'd0) begin
            if (owner) dbg_rdata <= mem_rdata;
            else       cpu_rdata <= mem_rdata;
            cpu_ack <= ~owner;
            dbg_ack <= owner;
            r_last  <= owner;
            r_state <= S_RESP;
          end else begin
            r_cnt <= r_cnt - 3'd1;
          end
        end

        S_RESP: begin
          cpu_ack <= 1'b0;
          dbg_ack <= 1'b0;
          r_state <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
